// File: rtl/stream_unpacker.sv
// Link receive unpacker: aligns to the idle-filled word stream, strips fill and
// re-emits header-led packets as AXI-Stream frames with start/BX0 sideband.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_UNLOCKED | hunting for a run of n_lock_words idle words, nothing emitted
// ST_LOCKED   | aligned; idles dropped, expecting a header
// ST_PAYLOAD  | forwarding packet payload words uninspected
module stream_unpacker #(
   parameter int DATA_WIDTH         = 32,
   parameter bit INPUT_REVERSE_BITS = 1'b1,
   parameter int COUNT_WIDTH        = 32
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic [DATA_WIDTH-1:0]  tdata_in,
   input  logic                   tvalid_in,
   output logic                   tready_in,
   output logic [DATA_WIDTH-1:0]  tdata_out,
   output logic                   tvalid_out,
   input  logic                   tready_out,
   output logic                   tlast_out,
   output logic [1:0]             tuser_out,
   input  logic [DATA_WIDTH-1:0]  idle_word,
   input  logic [DATA_WIDTH-1:0]  idle_word_BX0,
   input  logic [DATA_WIDTH-1:0]  header,
   input  logic [DATA_WIDTH-1:0]  header_BX0,
   input  logic [DATA_WIDTH-1:0]  header_mask,
   input  logic [15:0]            packet_len,
   input  logic [7:0]             n_lock_words,
   input  logic                   fc_linkReset,
   output logic                   locked,
   output logic [COUNT_WIDTH-1:0] packet_count,
   output logic [COUNT_WIDTH-1:0] bx0_count,
   output logic [15:0]            error_count
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_PAYLOAD  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [7:0]             run_q, run_d;
   logic [15:0]            remaining_q, remaining_d;
   logic [COUNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [COUNT_WIDTH-1:0] bx0_cnt_q, bx0_cnt_d;
   logic [15:0]            err_cnt_q, err_cnt_d;
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q, out_last_d;
   logic [1:0]             out_user_q, out_user_d;

   logic [DATA_WIDTH-1:0]  w;
   logic                   accept;
   logic                   is_idle, is_bx0_idle, is_hbx0, is_hdr;
   logic [7:0]             lock_target;
   logic [8:0]             run_next;

   always_comb begin
      for (int i = 0; i < DATA_WIDTH; i++)
         w[i] = INPUT_REVERSE_BITS ? tdata_in[DATA_WIDTH-1-i] : tdata_in[i];
   end

   assign tready_in   = !out_valid_q || tready_out;
   assign accept      = tvalid_in && tready_in;
   assign is_bx0_idle = (w == idle_word_BX0);
   assign is_idle     = (w == idle_word) || is_bx0_idle;
   assign is_hbx0     = (((w ^ header_BX0) & header_mask) == '0);
   assign is_hdr      = !is_hbx0 && (((w ^ header) & header_mask) == '0);
   assign lock_target = (n_lock_words == 8'd0) ? 8'd1 : n_lock_words;
   // widened so a lowered n_lock_words mid-run still terminates the hunt
   assign run_next    = {1'b0, run_q} + 9'd1;

   always_comb begin
      state_d     = state_q;
      run_d       = run_q;
      remaining_d = remaining_q;
      pkt_cnt_d   = pkt_cnt_q;
      bx0_cnt_d   = bx0_cnt_q;
      err_cnt_d   = err_cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_user_d  = out_user_q;

      if (out_valid_q && tready_out)
         out_valid_d = 1'b0;

      if (fc_linkReset) begin
         state_d = ST_UNLOCKED;
         run_d   = 8'd0;
         if (state_q == ST_PAYLOAD && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
      end else if (accept) begin
         case (state_q)
            ST_UNLOCKED: begin
               if (is_idle) begin
                  if (is_bx0_idle)
                     bx0_cnt_d = bx0_cnt_q + COUNT_WIDTH'(1);
                  if (run_next >= {1'b0, lock_target}) begin
                     state_d = ST_LOCKED;
                     run_d   = 8'd0;
                  end else begin
                     run_d = run_next[7:0];
                  end
               end else begin
                  run_d = 8'd0;
               end
            end
            ST_LOCKED: begin
               if (is_idle) begin
                  if (is_bx0_idle)
                     bx0_cnt_d = bx0_cnt_q + COUNT_WIDTH'(1);
               end else if (is_hbx0 || is_hdr) begin
                  out_data_d  = w;
                  out_valid_d = 1'b1;
                  out_user_d  = {is_hbx0, 1'b1};
                  out_last_d  = (packet_len == 16'd0);
                  pkt_cnt_d   = pkt_cnt_q + COUNT_WIDTH'(1);
                  if (is_hbx0)
                     bx0_cnt_d = bx0_cnt_q + COUNT_WIDTH'(1);
                  if (packet_len != 16'd0) begin
                     remaining_d = packet_len;
                     state_d     = ST_PAYLOAD;
                  end
               end else begin
                  if (err_cnt_q != 16'hFFFF)
                     err_cnt_d = err_cnt_q + 16'd1;
                  state_d = ST_UNLOCKED;
                  run_d   = 8'd0;
               end
            end
            ST_PAYLOAD: begin
               out_data_d  = w;
               out_valid_d = 1'b1;
               out_user_d  = 2'b00;
               out_last_d  = (remaining_q == 16'd1);
               remaining_d = remaining_q - 16'd1;
               if (remaining_q == 16'd1)
                  state_d = ST_LOCKED;
            end
            default: state_d = ST_UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= ST_UNLOCKED;
         run_q       <= 8'd0;
         remaining_q <= 16'd0;
         pkt_cnt_q   <= '0;
         bx0_cnt_q   <= '0;
         err_cnt_q   <= 16'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_user_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         remaining_q <= remaining_d;
         pkt_cnt_q   <= pkt_cnt_d;
         bx0_cnt_q   <= bx0_cnt_d;
         err_cnt_q   <= err_cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_user_q  <= out_user_d;
      end
   end

   assign tdata_out    = out_data_q;
   assign tvalid_out   = out_valid_q;
   assign tlast_out    = out_last_q;
   assign tuser_out    = out_user_q;
   assign locked       = (state_q != ST_UNLOCKED);
   assign packet_count = pkt_cnt_q;
   assign bx0_count    = bx0_cnt_q;
   assign error_count  = err_cnt_q;

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker: lock, packets, BX0, backpressure, errors
// and link reset, with output beats captured into queues by a monitor.
module tb_stream_unpacker;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [31:0] tdata_in;
   logic        tvalid_in;
   logic        tready_in;
   logic [31:0] tdata_out;
   logic        tvalid_out;
   logic        tready_out;
   logic        tlast_out;
   logic [1:0]  tuser_out;
   logic [31:0] idle_word, idle_word_BX0, header, header_BX0, header_mask;
   logic [15:0] packet_len;
   logic [7:0]  n_lock_words;
   logic        fc_linkReset;
   logic        locked;
   logic [31:0] packet_count, bx0_count;
   logic [15:0] error_count;

   int checks = 0;
   int errors = 0;
   int stall_viol = 0;
   bit bp_run = 0;

   logic [31:0] q_data[$];
   logic        q_last[$];
   logic [1:0]  q_user[$];

   stream_unpacker dut (
      .clk(clk), .aresetn(aresetn),
      .tdata_in(tdata_in), .tvalid_in(tvalid_in), .tready_in(tready_in),
      .tdata_out(tdata_out), .tvalid_out(tvalid_out), .tready_out(tready_out),
      .tlast_out(tlast_out), .tuser_out(tuser_out),
      .idle_word(idle_word), .idle_word_BX0(idle_word_BX0), .header(header),
      .header_BX0(header_BX0), .header_mask(header_mask),
      .packet_len(packet_len), .n_lock_words(n_lock_words),
      .fc_linkReset(fc_linkReset), .locked(locked),
      .packet_count(packet_count), .bx0_count(bx0_count), .error_count(error_count)
   );

   always #5 clk = ~clk;

   // inputs only change #1 after posedge, so negedge sees the values the next edge will use
   always @(negedge clk) begin
      if (tvalid_out && tready_out) begin
         q_data.push_back(tdata_out);
         q_last.push_back(tlast_out);
         q_user.push_back(tuser_out);
      end
      if (aresetn && tvalid_out && !tready_out && tready_in)
         stall_viol++;
   end

   function automatic logic [31:0] rev(input logic [31:0] v);
      return {<<{v}};
   endfunction

   task automatic clear_q();
      q_data.delete(); q_last.delete(); q_user.delete();
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [31:0] w);
      tdata_in  = rev(w);
      tvalid_in = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tready_in) begin
            @(posedge clk); #1;
            tvalid_in = 1'b0;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL send_timeout: word %h not accepted within 200 cycles", w);
      tvalid_in = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (tvalid_out !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b exp 0", tvalid_out); end
      checks++; if (tdata_out !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h exp 0", tdata_out); end
      checks++; if (tlast_out !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b exp 0", tlast_out); end
      checks++; if (tuser_out !== 2'b00) begin errors++; $display("FAIL rst_tuser: got %b exp 00", tuser_out); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b exp 0", locked); end
      checks++; if (packet_count !== 32'h0 || bx0_count !== 32'h0 || error_count !== 16'h0) begin
         errors++; $display("FAIL rst_counters: got %h %h %h exp 0 0 0", packet_count, bx0_count, error_count); end
      checks++; if (tready_in !== 1'b1) begin errors++; $display("FAIL rst_tready_in: got %b exp 1", tready_in); end
   endtask

   task automatic test_lock();
      clear_q();
      n_lock_words = 8'd4;
      repeat (3) send(32'hF7F7F7F7);
      send(32'h33333333);
      repeat (3) send(32'hF7F7F7F7);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b exp 0", locked); end
      send(32'hF7F7F7F7);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b exp 1", locked); end
      cycles(2);
      checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL lock_errcnt: got %0d exp 0", error_count); end
      checks++; if (q_data.size() !== 0) begin errors++; $display("FAIL lock_no_beats: got %0d exp 0", q_data.size()); end
   endtask

   task automatic test_packet();
      logic [31:0] exp_d [4] = '{32'hA0000005, 32'h11111111, 32'h22222222, 32'h33333333};
      logic [1:0]  exp_u [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
      logic        exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      clear_q();
      packet_len = 16'd3;
      for (int i = 0; i < 4; i++) send(exp_d[i]);
      send(32'hF7F7F7F7);
      cycles(3);
      checks++; if (q_data.size() !== 4) begin errors++; $display("FAIL pkt_beats: got %0d exp 4", q_data.size()); end
      for (int i = 0; i < 4 && i < q_data.size(); i++) begin
         checks++;
         if (q_data[i] !== exp_d[i] || q_user[i] !== exp_u[i] || q_last[i] !== exp_l[i]) begin
            errors++;
            $display("FAIL pkt_beat%0d: got %h/%b/%b exp %h/%b/%b", i, q_data[i], q_user[i], q_last[i], exp_d[i], exp_u[i], exp_l[i]);
         end
      end
      checks++; if (packet_count !== 32'd1) begin errors++; $display("FAIL pkt_count: got %0d exp 1", packet_count); end
   endtask

   task automatic test_bx0();
      clear_q();
      packet_len = 16'd0;
      send(32'h7CF7F7F7);
      send(32'h90000001);
      cycles(3);
      checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL bx0_beats: got %0d exp 1", q_data.size()); end
      if (q_data.size() > 0) begin
         checks++;
         if (q_data[0] !== 32'h90000001 || q_user[0] !== 2'b11 || q_last[0] !== 1'b1) begin
            errors++; $display("FAIL bx0_beat: got %h/%b/%b exp 90000001/11/1", q_data[0], q_user[0], q_last[0]);
         end
      end
      checks++; if (bx0_count !== 32'd2) begin errors++; $display("FAIL bx0_count: got %0d exp 2", bx0_count); end
      checks++; if (packet_count !== 32'd2) begin errors++; $display("FAIL bx0_pktcnt: got %0d exp 2", packet_count); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL bx0_locked: got %b exp 1", locked); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_d [17];
      clear_q();
      packet_len = 16'd16;
      exp_d[0] = 32'hA0000010;
      for (int i = 1; i < 17; i++) exp_d[i] = 32'hC0DE0000 + 32'(i);
      bp_run = 1;
      fork
         begin
            while (bp_run) begin
               @(posedge clk); #1;
               tready_out = 1'($urandom_range(0, 1));
            end
            tready_out = 1'b1;
         end
      join_none
      for (int i = 0; i < 17; i++) send(exp_d[i]);
      bp_run = 0;
      cycles(2);
      tready_out = 1'b1;
      cycles(4);
      checks++; if (q_data.size() !== 17) begin errors++; $display("FAIL bp_beats: got %0d exp 17", q_data.size()); end
      for (int i = 0; i < 17 && i < q_data.size(); i++) begin
         checks++;
         if (q_data[i] !== exp_d[i] || q_last[i] !== (i == 16) || q_user[i] !== ((i == 0) ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL bp_beat%0d: got %h/%b/%b exp %h", i, q_data[i], q_user[i], q_last[i], exp_d[i]);
         end
      end
      checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_tready_in: got %0d stalled-ready cycles exp 0", stall_viol); end
      checks++; if (packet_count !== 32'd3) begin errors++; $display("FAIL bp_pktcnt: got %0d exp 3", packet_count); end
   endtask

   task automatic test_error();
      clear_q();
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err_pre_locked: got %b exp 1", locked); end
      send(32'h12345678);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_locked: got %b exp 0", locked); end
      checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL err_count: got %0d exp 1", error_count); end
      cycles(3);
      checks++; if (q_data.size() !== 0) begin errors++; $display("FAIL err_no_beat: got %0d exp 0", q_data.size()); end
   endtask

   task automatic test_link_reset();
      clear_q();
      n_lock_words = 8'd4;
      repeat (4) send(32'hF7F7F7F7);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lr_relock: got %b exp 1", locked); end
      packet_len = 16'd8;
      send(32'hA0000008);
      for (int i = 1; i <= 3; i++) send(32'hD0000000 + 32'(i));
      fc_linkReset = 1'b1;
      cycles(1);
      fc_linkReset = 1'b0;
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lr_locked: got %b exp 0", locked); end
      checks++; if (error_count !== 16'd2) begin errors++; $display("FAIL lr_errcnt: got %0d exp 2", error_count); end
      send(32'h55555555);
      send(32'hA0000009);
      cycles(3);
      checks++; if (q_data.size() !== 4) begin errors++; $display("FAIL lr_beats: got %0d exp 4", q_data.size()); end
      for (int i = 0; i < q_data.size(); i++) begin
         checks++; if (q_last[i] !== 1'b0) begin errors++; $display("FAIL lr_no_tlast%0d: got %b exp 0", i, q_last[i]); end
      end
      n_lock_words = 8'd0;
      send(32'hF7F7F7F7);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lr_lock0: got %b exp 1", locked); end
      packet_len = 16'd1;
      send(32'hA0000007);
      packet_len = 16'd5;
      send(32'h0BADF00D);
      send(32'hF7F7F7F7);
      cycles(3);
      checks++; if (q_data.size() !== 6) begin errors++; $display("FAIL lr_new_beats: got %0d exp 6", q_data.size()); end
      if (q_data.size() == 6) begin
         checks++;
         if (q_data[4] !== 32'hA0000007 || q_user[4] !== 2'b01 || q_last[4] !== 1'b0 ||
             q_data[5] !== 32'h0BADF00D || q_user[5] !== 2'b00 || q_last[5] !== 1'b1) begin
            errors++; $display("FAIL lr_new_pkt: got %h/%b/%b %h/%b/%b exp a0000007/01/0 0badf00d/00/1",
                               q_data[4], q_user[4], q_last[4], q_data[5], q_user[5], q_last[5]);
         end
      end
      checks++; if (packet_count !== 32'd5) begin errors++; $display("FAIL lr_pktcnt: got %0d exp 5", packet_count); end
      checks++; if (error_count !== 16'd2) begin errors++; $display("FAIL lr_errcnt_end: got %0d exp 2", error_count); end
   endtask

   initial begin
      aresetn       = 1'b0;
      tdata_in      = 32'h0;
      tvalid_in     = 1'b0;
      tready_out    = 1'b1;
      idle_word     = 32'hF7F7F7F7;
      idle_word_BX0 = 32'h7CF7F7F7;
      header        = 32'hA0000000;
      header_BX0    = 32'h90000000;
      header_mask   = 32'hF0000000;
      packet_len    = 16'd0;
      n_lock_words  = 8'd4;
      fc_linkReset  = 1'b0;
      cycles(2);
      test_reset();
      aresetn = 1'b1;
      cycles(1);
      test_reset();
      test_lock();
      test_packet();
      test_bx0();
      test_backpressure();
      test_error();
      test_link_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
